// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared constants for the instruction fetch unit: bus widths, reset PC,
// NOP encoding and the fetch FSM state encodings.
package ysyx_23060332_ifu_pkg;

    localparam int unsigned InstBus     = 32;
    localparam int unsigned InstAddrBus = 32;

    localparam logic [InstAddrBus-1:0] ResetPC  = 32'h8000_0000;
    localparam logic [InstBus-1:0]     INST_NOP = 32'h0000_0013;

    // Fetch FSM state encodings
    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    // Sequential next PC, wraps modulo 2^32
    function automatic logic [InstAddrBus-1:0] pc_seq_next(input logic [InstAddrBus-1:0] pc);
        return pc + InstAddrBus'(4);
    endfunction

endpackage

// File: rtl/ysyx_23060332_pc_reg.sv
// Program counter register with next-pc selection: redirect, sequential
// advance or hold. Redirect has priority over advance.
module ysyx_23060332_pc_reg
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = ResetPC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next-pc mux
    always_comb begin
        pc_d = pc_q;
        if (jump_en_i) begin
            pc_d = jump_addr_i;
        end else if (advance_i) begin
            pc_d = pc_seq_next(pc_q);
        end
    end

    // PC state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and
// buffers the fetched instruction until decode accepts it. A redirect from
// execute overrides everything; an in-flight response made stale by a
// redirect is discarded in S_FLUSH.
// Optional build macro YSYX_23060332_IFU_MISALIGN_CHECK_EN adds
// fetch_misalign_o and blocks fetch from a misaligned PC until redirect.
module ysyx_23060332_ifu
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = ResetPC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i
`ifdef YSYX_23060332_IFU_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misalign_o
`endif
);

    logic [1:0]      state_q, state_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_addr_q, inst_addr_d;
    logic [XLEN-1:0] pc;
    logic            advance;
    logic            req_hs;

    // Sequential advance only on a decode handshake not overridden by redirect
    assign advance = (state_q == S_OUT) && inst_ready_i && !jump_en_i;

    ysyx_23060332_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .advance_i   (advance),
        .pc_o        (pc)
    );

`ifdef YSYX_23060332_IFU_MISALIGN_CHECK_EN
    logic misalign;
    assign misalign = (pc[1:0] != 2'b00);

    // Request gated by reset and PC alignment; flag self-clears once a redirect fixes the PC
    always_comb begin
        imem_req_valid   = !rst && (state_q == S_REQ) && !misalign;
        fetch_misalign_o = !rst && (state_q == S_REQ) && misalign;
        imem_req_addr    = pc;
    end
`else
    // Request gated by reset; address forced to word alignment
    always_comb begin
        imem_req_valid = !rst && (state_q == S_REQ);
        imem_req_addr  = pc & ~XLEN'(3);
    end
`endif

    assign req_hs = imem_req_valid && imem_req_ready;

    // Fetch FSM and output buffer next state
    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        case (state_q)
            S_REQ: begin
                if (jump_en_i) begin
                    // A request accepted this cycle is now stale
                    state_d = req_hs ? S_FLUSH : S_REQ;
                end else if (req_hs) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (jump_en_i) begin
                    state_d = imem_resp_valid ? S_REQ : S_FLUSH;
                end else if (imem_resp_valid) begin
                    inst_d       = imem_resp_data;
                    inst_addr_d  = pc;
                    inst_valid_d = 1'b1;
                    state_d      = S_OUT;
                end
            end
            S_OUT: begin
                if (jump_en_i || inst_ready_i) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_FLUSH: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // FSM and output buffer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            inst_valid_q <= 1'b0;
            inst_q       <= INST_NOP;
            inst_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
        end
    end

    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Bench for ysyx_23060332_ifu: directed scenarios followed by a randomized run
// checked against a transaction-level model of the expected PC stream.
module tb_ysyx_23060332_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
`ifdef YSYX_23060332_IFU_MISALIGN_CHECK_EN
    logic        fetch_misalign_o;
`endif

    int n_chk = 0;
    int n_err = 0;

    ysyx_23060332_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_addr_o     (inst_addr_o),
        .jump_en_i       (jump_en_i),
        .jump_addr_i     (jump_addr_i)
`ifdef YSYX_23060332_IFU_MISALIGN_CHECK_EN
        ,
        .fetch_misalign_o (fetch_misalign_o)
`endif
    );

    always #5 clk = ~clk;

    // Memory model configuration
    bit          ready_rand = 1'b0;
    bit          ready_fix  = 1'b1;
    bit          lat_rand   = 1'b0;
    int          lat_fix    = 1;
    bit          use_fix    = 1'b0;
    logic [31:0] fix_data   = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    // Memory model: handshake latched at negedge, response driven at posedge+1
    bit          mem_hs;
    logic [31:0] mem_hs_addr;
    bit          mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    initial begin
        forever begin
            @(negedge clk);
            mem_hs      = !rst && imem_req_valid && imem_req_ready;
            mem_hs_addr = imem_req_addr;
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (rst) begin
                mem_pending = 1'b0;
            end else begin
                if (mem_hs) begin
                    mem_pending = 1'b1;
                    mem_addr    = mem_hs_addr;
                    mem_cnt     = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
                end
                if (mem_pending) begin
                    if (mem_cnt <= 1) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = use_fix ? fix_data : mem_word(mem_addr);
                        mem_pending     = 1'b0;
                    end else begin
                        mem_cnt = mem_cnt - 1;
                    end
                end
            end
            imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        step();
        n_chk += 5;
        if (imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
        end
        if (inst_valid_o !== 1'b0) begin
            n_err++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid_o);
        end
        if (inst_o !== NOP) begin
            n_err++; $display("FAIL reset_inst: got %h expected %h", inst_o, NOP);
        end
        if (inst_addr_o !== 32'h0) begin
            n_err++; $display("FAIL reset_inst_addr: got %h expected 0", inst_addr_o);
        end
        if (imem_req_addr !== RST_PC) begin
            n_err++; $display("FAIL reset_req_addr: got %h expected %h", imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_first_fetch();
        use_fix  = 1'b1;
        fix_data = 32'h0010_0093;
        step();
        rst = 1'b0;
        #1;
        n_chk += 2;
        if (imem_req_valid !== 1'b1) begin
            n_err++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid);
        end
        if (imem_req_addr !== RST_PC) begin
            n_err++; $display("FAIL first_req_addr: got %h expected %h", imem_req_addr, RST_PC);
        end
        step();
        n_chk += 2;
        if (imem_req_valid !== 1'b0 || inst_valid_o !== 1'b0) begin
            n_err++; $display("FAIL first_wait: got req_valid=%b inst_valid=%b expected 0/0",
                              imem_req_valid, inst_valid_o);
        end
        step();
        if (inst_valid_o !== 1'b1) begin
            n_err++; $display("FAIL first_inst_valid: got %b expected 1", inst_valid_o);
        end
        n_chk += 2;
        if (inst_o !== 32'h0010_0093) begin
            n_err++; $display("FAIL first_inst: got %h expected 00100093", inst_o);
        end
        if (inst_addr_o !== RST_PC) begin
            n_err++; $display("FAIL first_inst_addr: got %h expected %h", inst_addr_o, RST_PC);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if (inst_valid_o !== 1'b1 || inst_o !== 32'h0010_0093 || inst_addr_o !== RST_PC
                || imem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b inst=%h addr=%h req=%b expected 1/00100093/%h/0",
                         inst_valid_o, inst_o, inst_addr_o, imem_req_valid, RST_PC);
            end
        end
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        n_chk++;
        if (inst_valid_o !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 4) begin
            n_err++;
            $display("FAIL stall_release: got v=%b req=%b addr=%h expected 0/1/%h",
                     inst_valid_o, imem_req_valid, imem_req_addr, RST_PC + 4);
        end
    endtask

    task automatic test_redirect_wait();
        int cyc;
        bit saw_valid;
        lat_fix = 3;
        use_fix = 1'b0;
        step();
        n_chk++;
        if (imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL rw_in_wait: got req_valid=%b expected 0", imem_req_valid);
        end
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h8000_0100;
        step();
        jump_en_i = 1'b0;
        cyc = 0;
        saw_valid = 1'b0;
        while (!imem_req_valid && cyc < 10) begin
            if (inst_valid_o) saw_valid = 1'b1;
            step();
            cyc++;
        end
        lat_fix = 1;
        n_chk += 3;
        if (saw_valid || inst_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rw_dropped: got inst_valid seen=%b expected 0", saw_valid);
        end
        if (cyc != 2) begin
            n_err++; $display("FAIL rw_flush_cycles: got %0d expected 2", cyc);
        end
        if (imem_req_addr !== 32'h8000_0100) begin
            n_err++; $display("FAIL rw_addr: got %h expected 80000100", imem_req_addr);
        end
    endtask

    task automatic test_redirect_out();
        int cyc = 0;
        while (!inst_valid_o && cyc < 10) begin
            step();
            cyc++;
        end
        n_chk += 2;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h8000_0100) begin
            n_err++; $display("FAIL ro_fetch: got v=%b addr=%h expected 1/80000100",
                              inst_valid_o, inst_addr_o);
        end
        if (inst_o !== mem_word(32'h8000_0100)) begin
            n_err++; $display("FAIL ro_data: got %h expected %h", inst_o, mem_word(32'h8000_0100));
        end
        inst_ready_i = 1'b1;
        jump_en_i    = 1'b1;
        jump_addr_i  = 32'h8000_0200;
        ready_fix    = 1'b0;
        step();
        inst_ready_i = 1'b0;
        jump_en_i    = 1'b0;
        n_chk++;
        if (inst_valid_o !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
            n_err++; $display("FAIL ro_redirect: got v=%b req=%b addr=%h expected 0/1/80000200",
                              inst_valid_o, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_req_stall_wrap();
        int cyc = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
                n_err++; $display("FAIL rs_hold: got req=%b addr=%h expected 1/80000200",
                                  imem_req_valid, imem_req_addr);
            end
        end
        jump_en_i   = 1'b1;
        jump_addr_i = 32'hFFFF_FFFC;
        step();
        jump_en_i    = 1'b0;
        ready_fix    = 1'b1;
        inst_ready_i = 1'b1;
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL rs_jump_addr: got req=%b addr=%h expected 1/fffffffc",
                              imem_req_valid, imem_req_addr);
        end
        while (!inst_valid_o && cyc < 10) begin
            step();
            cyc++;
        end
        n_chk++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'hFFFF_FFFC
            || inst_o !== mem_word(32'hFFFF_FFFC)) begin
            n_err++; $display("FAIL rs_top_fetch: got v=%b addr=%h inst=%h expected 1/fffffffc/%h",
                              inst_valid_o, inst_addr_o, inst_o, mem_word(32'hFFFF_FFFC));
        end
        step();
        inst_ready_i = 1'b0;
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_err++; $display("FAIL rs_wrap: got req=%b addr=%h expected 1/00000000",
                              imem_req_valid, imem_req_addr);
        end
    endtask

    // Model: the delivered stream is sequential words from the last redirect target
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] r;
        logic [31:0] prev_inst, prev_addr;
        bit          hold_prev = 1'b0;
        int          delivered = 0;
        ready_rand = 1'b1;
        lat_rand   = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_pc = RST_PC;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i == 1500) begin
                rst = 1'b1;
                jump_en_i = 1'b0;
                #1;
                n_chk++;
                if (inst_valid_o !== 1'b0 || imem_req_valid !== 1'b0 || inst_o !== NOP
                    || inst_addr_o !== 32'h0) begin
                    n_err++; $display("FAIL rand_mid_reset: got v=%b req=%b inst=%h addr=%h",
                                      inst_valid_o, imem_req_valid, inst_o, inst_addr_o);
                end
                step();
                step();
                rst = 1'b0;
                exp_pc = RST_PC;
                hold_prev = 1'b0;
            end else begin
                jump_en_i = ($urandom_range(0, 7) == 0);
                r = $urandom;
                jump_addr_i = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
                inst_ready_i = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (hold_prev) begin
                n_chk++;
                if (inst_valid_o !== 1'b1 || inst_o !== prev_inst || inst_addr_o !== prev_addr) begin
                    n_err++; $display("FAIL rand_hold: got v=%b inst=%h addr=%h expected 1/%h/%h",
                                      inst_valid_o, inst_o, inst_addr_o, prev_inst, prev_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                n_chk++;
                if (imem_req_addr !== exp_pc) begin
                    n_err++; $display("FAIL rand_req_addr: got %h expected %h", imem_req_addr, exp_pc);
                end
            end
            if (jump_en_i) begin
                exp_pc = jump_addr_i;
            end else if (inst_valid_o && inst_ready_i) begin
                n_chk++;
                if (inst_addr_o !== exp_pc || inst_o !== mem_word(exp_pc)) begin
                    n_err++; $display("FAIL rand_deliver: got addr=%h inst=%h expected %h/%h",
                                      inst_addr_o, inst_o, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            hold_prev = inst_valid_o && !inst_ready_i && !jump_en_i;
            prev_inst = inst_o;
            prev_addr = inst_addr_o;
        end
        jump_en_i = 1'b0;
        inst_ready_i = 1'b0;
        n_chk++;
        if (delivered < 50) begin
            n_err++; $display("FAIL rand_progress: got %0d deliveries expected at least 50", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_out();
        test_req_stall_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
